// File: rtl/wired_bus_arbiter.sv
// Round-robin owner sequencer for one shared wired/tri-state net: one tenure at a time,
// bounded bursts, all-Z turnaround between owners, and a readback contention check.
module wired_bus_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BEATS = 4,
  parameter int TURN_CYC  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    last,
  input  logic [N_REQ*DW-1:0] wdata,
  input  logic [DW-1:0]       bus_din,
  input  logic                err_clr,
  output logic [N_REQ-1:0]    gnt,
  output logic                bus_oe,
  output logic [DW-1:0]       bus_dout,
  output logic                beat_done,
  output logic                busy,
  output logic                err_contention,
  output logic [1:0]          dbg_state
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, TURN = 2'd2} state_e;

  state_e           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic             bus_oe_q;
  logic [IW-1:0]    owner_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [3:0]       beat_cnt_q;
  logic [1:0]       turn_cnt_q;
  logic             err_q;
  logic             err_d;

  logic [IW-1:0]    sel_idx;
  logic [N_REQ-1:0] sel_onehot;
  logic             sel_valid;
  logic [IW:0]      scan;
  logic [IW-1:0]    next_ptr;
  logic             owner_req;
  logic             owner_last;
  logic             tenure_end;
  logic             mismatch;

  // Scan downward so the lowest offset from rr_ptr_q is the last (winning) assignment.
  always_comb begin
    sel_valid  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    scan       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(N_REQ)) scan = scan - (IW+1)'(N_REQ);
      if (req[scan[IW-1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = scan[IW-1:0];
      end
    end
    sel_onehot[sel_idx] = 1'b1;
  end

  // req[o] high in OWN is a transferred beat; the owner holds wdata until it drops req.
  assign owner_req  = req[owner_q];
  assign owner_last = last[owner_q];
  assign tenure_end = !owner_req || owner_last || (beat_cnt_q == 4'(MAX_BEATS - 1));
  assign next_ptr   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);

  assign bus_dout  = bus_oe_q ? wdata[int'(owner_q)*DW +: DW] : '0;
  assign mismatch  = (state_q == OWN) && (bus_din !== bus_dout);
  assign err_d     = mismatch ? 1'b1 : (err_clr ? 1'b0 : err_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      bus_oe_q   <= 1'b0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      turn_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      unique case (state_q)
        IDLE: begin
          if (sel_valid) begin
            state_q    <= OWN;
            gnt_q      <= sel_onehot;
            bus_oe_q   <= 1'b1;
            owner_q    <= sel_idx;
            beat_cnt_q <= '0;
          end
        end
        OWN: begin
          if (owner_req) beat_cnt_q <= beat_cnt_q + 4'd1;
          if (tenure_end) begin
            gnt_q      <= '0;
            bus_oe_q   <= 1'b0;
            rr_ptr_q   <= next_ptr;
            turn_cnt_q <= '0;
            state_q    <= (TURN_CYC > 0) ? TURN : IDLE;
          end
        end
        TURN: begin
          if (turn_cnt_q == 2'(TURN_CYC - 1)) state_q <= IDLE;
          else turn_cnt_q <= turn_cnt_q + 2'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt            = gnt_q;
  assign bus_oe         = bus_oe_q;
  assign beat_done      = (state_q == OWN) && owner_req;
  assign busy           = (state_q != IDLE);
  assign err_contention = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_wired_bus_arbiter.sv
// Bench for wired_bus_arbiter: instance a has a 1-cycle turnaround, instance b has none.
// A tenure-level model predicts every output each cycle; directed steps pin literal values.
module tb_wired_bus_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req, last;
  logic [31:0] wdata;
  logic        err_clr, force_din;
  logic [7:0]  din_val;
  logic [7:0]  din_a, din_b;

  logic [3:0] gnt_a, gnt_b;
  logic       oe_a, oe_b, beat_a, beat_b, busy_a, busy_b, err_a, err_b;
  logic [7:0] dout_a, dout_b;
  logic [1:0] st_a, st_b;

  assign din_a = force_din ? din_val : dout_a;
  assign din_b = dout_b;

  wired_bus_arbiter #(.N_REQ(N), .DW(8), .MAX_BEATS(MB), .TURN_CYC(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .wdata(wdata), .bus_din(din_a),
    .err_clr(err_clr), .gnt(gnt_a), .bus_oe(oe_a), .bus_dout(dout_a), .beat_done(beat_a),
    .busy(busy_a), .err_contention(err_a), .dbg_state(st_a));

  wired_bus_arbiter #(.N_REQ(N), .DW(8), .MAX_BEATS(MB), .TURN_CYC(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .wdata(wdata), .bus_din(din_b),
    .err_clr(err_clr), .gnt(gnt_b), .bus_oe(oe_b), .bus_dout(dout_b), .beat_done(beat_b),
    .busy(busy_b), .err_contention(err_b), .dbg_state(st_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- tenure-level model ----------------
  int   m_owner[2] = '{-1, -1};
  int   m_beats[2] = '{0, 0};
  int   m_dead[2]  = '{0, 0};
  int   m_ptr[2]   = '{0, 0};
  logic m_err[2]   = '{1'b0, 1'b0};

  function automatic int turn_of(int j);
    return (j == 0) ? 1 : 0;
  endfunction

  function automatic logic [7:0] exp_dout(int j);
    if (m_owner[j] < 0) return 8'h00;
    return wdata[m_owner[j]*8 +: 8];
  endfunction

  task automatic model_step(input int j, input logic [7:0] din);
    int o;
    o = m_owner[j];
    if (o >= 0 && (din !== exp_dout(j))) m_err[j] = 1'b1;
    else if (err_clr) m_err[j] = 1'b0;
    if (o >= 0) begin
      if (!req[o] || last[o] || (m_beats[j] + 1 == MB)) begin
        m_ptr[j]   = (o + 1) % N;
        m_owner[j] = -1;
        m_dead[j]  = turn_of(j);
      end else begin
        m_beats[j]++;
      end
    end else if (m_dead[j] > 0) begin
      m_dead[j]--;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_owner[j] < 0 && req[(m_ptr[j] + k) % N]) begin
          m_owner[j] = (m_ptr[j] + k) % N;
          m_beats[j] = 0;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 2; j++) begin
        m_owner[j] = -1; m_beats[j] = 0; m_dead[j] = 0; m_ptr[j] = 0; m_err[j] = 1'b0;
      end
    end else begin
      model_step(0, force_din ? din_val : exp_dout(0));
      model_step(1, exp_dout(1));
    end
  end

  task automatic cmp(input int j, input logic [3:0] g, input logic oe, input logic [7:0] d,
                     input logic b, input logic bz, input logic e, input logic [1:0] st);
    string s;
    logic [3:0] eg;
    logic       own;
    s   = (j == 0) ? "a" : "b";
    own = (m_owner[j] >= 0);
    eg  = own ? 4'(1 << m_owner[j]) : 4'b0000;
    chk({"gnt_", s}, g, eg);
    chk({"bus_oe_", s}, oe, own);
    chk({"bus_dout_", s}, d, exp_dout(j));
    chk({"beat_done_", s}, b, own && req[m_owner[j]]);
    chk({"busy_", s}, bz, own || (m_dead[j] > 0));
    chk({"err_", s}, e, m_err[j]);
    chk({"state_", s}, st, own ? 2'd1 : ((m_dead[j] > 0) ? 2'd2 : 2'd0));
  endtask

  always @(negedge clk) begin
    cmp(0, gnt_a, oe_a, dout_a, beat_a, busy_a, err_a, st_a);
    cmp(1, gnt_b, oe_b, dout_b, beat_b, busy_b, err_b, st_b);
  end

  // ---------------- monitor on instance a: grant order, beats, gaps ----------------
  int obs_q[$];
  int beat_q[$];
  int gap_q[$];
  logic [3:0] prev_gnt = 4'b0;
  int mon_beats = 0;
  int mon_gap = 0;
  logic mon_had = 1'b0;

  function automatic int idx_of(logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (gnt_a != 4'b0) begin
      if (prev_gnt == 4'b0) begin
        obs_q.push_back(idx_of(gnt_a));
        if (mon_had) gap_q.push_back(mon_gap);
        mon_beats = 0;
      end
      if (beat_a) mon_beats++;
    end else begin
      if (prev_gnt != 4'b0) begin
        beat_q.push_back(mon_beats);
        mon_had = 1'b1;
        mon_gap = 0;
      end
      mon_gap++;
    end
    prev_gnt = gnt_a;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; last = '0; err_clr = 1'b0; force_din = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  logic [3:0] exp_q[$];
  int ob, bb, gb;

  initial begin
    rst_n = 1'b0; req = '0; last = '0; wdata = '0; err_clr = 1'b0;
    force_din = 1'b0; din_val = 8'h00;
    tick(3);
    chk("rst_gnt", gnt_a, 4'b0000);
    chk("rst_oe", oe_a, 1'b0);
    chk("rst_dout", dout_a, 8'h00);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    rst_n = 1'b1;

    // single owner, last on beat 2
    bb = beat_q.size();
    req = 4'b0100; wdata = 32'h00A5_0000;
    tick(1);
    chk("t1_gnt", gnt_a, 4'b0100);
    chk("t1_dout", dout_a, 8'hA5);
    chk("t1_beat", beat_a, 1'b1);
    tick(1);
    last = 4'b0100;
    tick(1);
    chk("t1_turn_oe", oe_a, 1'b0);
    chk("t1_turn_busy", busy_a, 1'b1);
    req = '0; last = '0;
    tick(1);
    chk("t1_busy_fall", busy_a, 1'b0);
    chk("t1_beats", (bb < beat_q.size()) ? beat_q[bb] : -1, 2);

    // all requesting, round robin with full bursts
    do_reset();
    ob = obs_q.size(); bb = beat_q.size(); gb = gap_q.size();
    req = 4'b1111; wdata = 32'h4433_2211;
    tick(26);
    req = '0;
    tick(4);
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("t2_order%0d", i), (ob + i < obs_q.size()) ? obs_q[ob + i] : -1, 32'(exp_q[i]));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_beats%0d", i), (bb + i < beat_q.size()) ? beat_q[bb + i] : -1, 4);
      chk($sformatf("t2_gap%0d", i), (gb + 1 + i < gap_q.size()) ? gap_q[gb + 1 + i] : -1, 2);
    end

    // owner 1 drops req after one beat, requester 3 waiting
    bb = beat_q.size();
    req = 4'b1010;
    tick(1);
    chk("t3_gnt1", gnt_a, 4'b0010);
    tick(1);
    req = 4'b1000;
    tick(3);
    chk("t3_gnt3", gnt_a, 4'b1000);
    chk("t3_beats1", (bb < beat_q.size()) ? beat_q[bb] : -1, 1);
    req = '0;
    tick(3);
    req = 4'b1111;
    tick(1);
    chk("t3_ptr_wrap", gnt_a, 4'b0001);
    req = '0;
    tick(3);

    // contention detection and clearing
    wdata = 32'h0000_FF00; req = 4'b0010;
    tick(1);
    chk("t4_gnt", gnt_a, 4'b0010);
    force_din = 1'b1; din_val = 8'h00;
    tick(1);
    chk("t4_err_set", err_a, 1'b1);
    force_din = 1'b0;
    tick(1);
    chk("t4_err_sticky", err_a, 1'b1);
    err_clr = 1'b1;
    tick(1);
    chk("t4_err_clr", err_a, 1'b0);
    force_din = 1'b1; din_val = 8'hxz;
    tick(1);
    chk("t4_set_wins", err_a, 1'b1);
    err_clr = 1'b0; force_din = 1'b0; req = '0;
    tick(3);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t4_err_idle_clr", err_a, 1'b0);

    // reset in the middle of a tenure
    req = 4'b0010;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_gnt_async", gnt_a, 4'b0000);
    chk("t5_oe_async", oe_a, 1'b0);
    chk("t5_beat_async", beat_a, 1'b0);
    req = 4'b0101;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("t5_gnt_after_rst", gnt_a, 4'b0001);
    req = '0;
    tick(3);

    // zero turnaround on instance b
    do_reset();
    req = 4'b0011; last = 4'b0001; wdata = 32'h0000_2211;
    tick(1);
    chk("t6_gnt0_b", gnt_b, 4'b0001);
    tick(1);
    chk("t6_idle_gnt_b", gnt_b, 4'b0000);
    chk("t6_idle_state_b", st_b, 2'd0);
    tick(1);
    chk("t6_gnt1_b", gnt_b, 4'b0010);
    chk("t6_turn_gnt_a", gnt_a, 4'b0000);
    tick(1);
    chk("t6_gnt1_a", gnt_a, 4'b0010);
    req = '0; last = '0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wired_bus_arbiter.md
Name: wired_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared multi-driven data net (wand/wor/tri-resolved) that several requesters must time-share.
- Grants exactly one owner at a time and drives that owner's data with an output enable.
- Bounds each tenure to a burst, inserts a release (all-Z) turnaround between owners, and reads back the resolved net to flag contention.
- Sits between requester logic and the shared net's tri-state driver.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- DW, 8: shared net data width.
- MAX_BEATS, 4: maximum beats per tenure (1..15).
- TURN_CYC, 1: idle turnaround cycles after each tenure (0..3).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester bus request, level.
- last  input  N_REQ  per-requester final-beat marker, qualified by req.
- wdata  input  N_REQ*DW  per-requester data, slice i = wdata[i*DW +: DW].
- bus_din  input  DW  resolved value read back from the shared net.
- err_clr  input  1  clears err_contention.
- gnt  output  N_REQ  one-hot grant, registered.
- bus_oe  output  1  drive enable for the shared net; 0 means release to Z.
- bus_dout  output  DW  value to drive: wdata slice of the owner when bus_oe=1, else 0.
- beat_done  output  1  a beat transfers this cycle.
- busy  output  1  state is not IDLE.
- err_contention  output  1  sticky readback-mismatch flag.

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt=0, bus_oe=0, bus_dout=0, beat_done=0, busy=0, err_contention=0, rr_ptr=0, beat_cnt=0.
- Reset mid-tenure drops gnt and bus_oe immediately, with no turnaround.
- States: IDLE, OWN, TURN.
- IDLE:
  - If any req, select the first asserted req scanning upward from rr_ptr, modulo N_REQ.
  - Next edge: gnt=onehot(sel), bus_oe=1, beat_cnt=0, go to OWN.
  - Grant latency is 1 cycle from the req-sampled edge.
- OWN, owner o:
  - bus_dout = wdata slice o, combinational.
  - beat_done = req[o]. A beat transfers on each cycle where req[o]=1; beat_cnt increments at the edge.
  - The tenure ends at the edge where any of these holds:
    - beat with last[o]=1;
    - beat with beat_cnt==MAX_BEATS-1;
    - req[o]=0 (no beat that cycle).
  - On tenure end: gnt=0, bus_oe=0, rr_ptr=(o+1) mod N_REQ.
  - Next state is TURN if TURN_CYC>0, else IDLE.
- TURN:
  - gnt=0, bus_oe=0 for exactly TURN_CYC cycles, then IDLE.
  - Requests are ignored until back in IDLE.
  - Minimum dead time between two tenures is TURN_CYC+1 cycles (turnaround plus the arbitration cycle).
- Grant fairness:
  - The owner cannot be preempted.
  - Requests that arrive during OWN or TURN wait.
  - A continuously requesting requester is granted within N_REQ-1 other tenures.
- Contention check:
  - In OWN, if (bus_din !== bus_dout), case-inequality so X/Z counts as a mismatch, then err_contention=1 at the next edge.
  - No check while bus_oe=0.
  - err_clr=1 clears err_contention at the edge unless a mismatch is detected in the same cycle; set wins.
- Grant and bus_oe are driven only from registers.
- gnt is never multi-hot; bus_oe==|gnt at all times.

Test Plan:
- Reset then req=4'b0100, last[2] high on beat 2, wdata[2]=8'hA5, bus_din=bus_dout → gnt=4'b0100 one cycle after req, bus_dout=8'hA5, beat_done for exactly 2 cycles, then 1 TURN cycle with bus_oe=0, busy falls 2 cycles after the last beat.
- req=4'b1111 held, last=0, MAX_BEATS=4 → grants in order 0,1,2,3,0; each tenure exactly 4 beats; one-hot gnt; 2 dead cycles between tenures.
- Owner 1 drops req after 1 beat with req[3]=1 → tenure ends after 1 beat, next grant goes to 3, rr_ptr becomes 2 then 0.
- During OWN force bus_din=8'h00 while bus_dout=8'hFF, and separately bus_din=8'hxz → err_contention=1 next edge and stays set; err_clr with no mismatch clears it; err_clr during a mismatch leaves it 1.
- rst_n asserted mid-beat 2 of a tenure → gnt, bus_oe, beat_done go 0 asynchronously; after release, req=4'b0001 is granted with rr_ptr=0.
- TURN_CYC=0, req=4'b0011 → owner 0 tenure, IDLE one cycle, owner 1 granted next, no TURN state entered.
